alu_ext_seq: RTL

- Parametrised, multi-cycle successor to the 8-bit ALU operand/carry extender.
- Performs WIDTH-bit add, add-with-carry, subtract and subtract-with-borrow. The work is done one SLICE-bit chunk per clock, with the carry chained between chunks.
- Sits beside the 8-bit datapath, so wide (16/32-bit) arithmetic reuses a narrow adder.
- Reports carry/borrow, zero and signed-overflow flags, using a start/busy/done handshake.

---
 rtl/alu_ext_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_ext_seq.sv
// Multi-cycle WIDTH-bit add/sub engine: one SLICE-bit chunk per clock with the carry chained
// between chunks. Reports carry/borrow, zero and signed overflow through a start/busy/done handshake.
module alu_ext_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             z_out,
    output logic             v_out
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_q, c_d, z_q, z_d, v_q, v_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [SLICE-1:0] a_sl [NSLICE];
    logic [SLICE-1:0] b_sl [NSLICE];
    logic [SLICE-1:0] cur_a, cur_b;
    logic [SLICE:0]   sum_w;

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
        assign a_sl[gi] = opa_q[gi*SLICE +: SLICE];
        assign b_sl[gi] = opb_q[gi*SLICE +: SLICE];
    end

    always_comb begin
        cur_a = '0;
        cur_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDXW'(i)) begin
                cur_a = a_sl[i];
                cur_b = b_sl[i];
            end
        end
    end

    assign sum_w = {1'b0, cur_a} + {1'b0, cur_b} + (SLICE+1)'(carry_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        c_d      = c_q;
        z_d      = z_q;
        v_d      = v_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = op[1] ? ~b : b;
                    sub_d   = op[1];
                    // c0: 00->0, 01->cin, 10->1, 11->~cin
                    carry_d = op[0] ? (cin ^ op[1]) : op[1];
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (idx_q == IDXW'(i)) result_d[i*SLICE +: SLICE] = sum_w[SLICE-1:0];
                end
                carry_d = sum_w[SLICE];
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                    done_d  = 1'b1;
                    c_d     = sum_w[SLICE] ^ sub_q;
                    z_d     = (result_d == '0);
                    // carry into the MSB is recovered from the MSB sum bit and its operands
                    v_d     = sum_w[SLICE] ^ (sum_w[SLICE-1] ^ cur_a[SLICE-1] ^ cur_b[SLICE-1]);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
            v_q      <= v_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign c_out  = c_q;
    assign z_out  = z_q;
    assign v_out  = v_q;
endmodule
